decode_stage_pipelined: RTL and testbench

DECODE_STAGE_PIPELINED -- requirements
Module: decode_stage_pipelined

---
 rtl/decode_stage_pipelined_if.sv | 40 ++++
 rtl/decode_stage_pipelined.sv | 116 +++++++++++
 tb/tb_decode_stage_pipelined.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pipelined_if.sv
// Handshake and data bundle between the fetch side, the write-back path
// and the pipelined decode stage.
interface decode_stage_pipelined_if #(
    parameter int DATA_WIDTH = 32
);
    // upstream instruction handshake
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instruction;
    // register-file write-back
    logic                  wb_en;
    logic [4:0]            wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    // downstream decoded bundle
    logic                  out_valid;
    logic                  out_ready;
    logic [5:0]            opcode;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [4:0]            shamt;
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic [DATA_WIDTH-1:0] extended_immediate;

    // environment side: presents instructions and write-backs, consumes bundles
    modport master (
        output in_valid, instruction, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
               read_data_1, read_data_2, extended_immediate
    );

    // decode stage side
    modport slave (
        input  in_valid, instruction, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
               read_data_1, read_data_2, extended_immediate
    );
endinterface

// File: rtl/decode_stage_pipelined.sv
// MIPS decode stage: field extraction, 32-entry register file with
// write-back bypass, immediate extension and a single output register
// behind a valid/ready handshake.
module decode_stage_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ZERO_EXT_LOGIC = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    decode_stage_pipelined_if.slave bus
);
    logic [DATA_WIDTH-1:0] regs [0:31];

    logic [5:0]            opcode_reg;
    logic [4:0]            rs_reg;
    logic [4:0]            rt_reg;
    logic [4:0]            rd_reg;
    logic [4:0]            shamt_reg;
    logic [5:0]            funct_reg;
    logic [DATA_WIDTH-1:0] rd1_reg;
    logic [DATA_WIDTH-1:0] rd2_reg;
    logic [DATA_WIDTH-1:0] imm_reg;
    logic                  valid_reg;

    logic [5:0]            inst_opcode;
    logic [4:0]            inst_rs;
    logic [4:0]            inst_rt;
    logic [15:0]           inst_imm;
    logic                  wb_hit;
    logic                  accept;
    logic                  zero_ext;
    logic [DATA_WIDTH-1:0] rd1_next;
    logic [DATA_WIDTH-1:0] rd2_next;
    logic [DATA_WIDTH-1:0] imm_next;

    assign inst_opcode = bus.instruction[31:26];
    assign inst_rs     = bus.instruction[25:21];
    assign inst_rt     = bus.instruction[20:16];
    assign inst_imm    = bus.instruction[15:0];

    // writes to register 0 never land and never bypass
    assign wb_hit   = bus.wb_en && (bus.wb_addr != 5'd0);
    assign bus.in_ready = !valid_reg || bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;

    // Register file: entry 0 is a constant zero flop, the rest take write-back.
    // Reads are combinational so the operands are captured in the same cycle.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_regfile
            // one entry: cleared by reset, loaded on a matching write-back
            always_ff @(posedge clk) begin
                if (reset || gi == 0) begin
                    regs[gi] <= '0;
                end else if (bus.wb_en && bus.wb_addr == 5'(gi)) begin
                    regs[gi] <= bus.wb_data;
                end
            end
        end
    endgenerate

    // Operand read with same-edge write-back forwarding; immediate extension
    always_comb begin
        rd1_next = regs[inst_rs];
        rd2_next = regs[inst_rt];
        if (wb_hit && bus.wb_addr == inst_rs) rd1_next = bus.wb_data;
        if (wb_hit && bus.wb_addr == inst_rt) rd2_next = bus.wb_data;
        zero_ext = (ZERO_EXT_LOGIC != 0) &&
                   (inst_opcode == 6'h0C || inst_opcode == 6'h0D || inst_opcode == 6'h0E);
        if (zero_ext) imm_next = {{(DATA_WIDTH-16){1'b0}}, inst_imm};
        else          imm_next = {{(DATA_WIDTH-16){inst_imm[15]}}, inst_imm};
    end

    // Output register: capture on accept, drop valid on drain, and keep held
    // operands fresh against write-backs while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg  <= 1'b0;
            opcode_reg <= '0;
            rs_reg     <= '0;
            rt_reg     <= '0;
            rd_reg     <= '0;
            shamt_reg  <= '0;
            funct_reg  <= '0;
            rd1_reg    <= '0;
            rd2_reg    <= '0;
            imm_reg    <= '0;
        end else if (accept) begin
            valid_reg  <= 1'b1;
            opcode_reg <= inst_opcode;
            rs_reg     <= inst_rs;
            rt_reg     <= inst_rt;
            rd_reg     <= bus.instruction[15:11];
            shamt_reg  <= bus.instruction[10:6];
            funct_reg  <= bus.instruction[5:0];
            rd1_reg    <= rd1_next;
            rd2_reg    <= rd2_next;
            imm_reg    <= imm_next;
        end else if (valid_reg && bus.out_ready) begin
            valid_reg <= 1'b0;
        end else if (valid_reg) begin
            if (wb_hit && bus.wb_addr == rs_reg) rd1_reg <= bus.wb_data;
            if (wb_hit && bus.wb_addr == rt_reg) rd2_reg <= bus.wb_data;
        end
    end

    assign bus.out_valid          = valid_reg;
    assign bus.opcode             = opcode_reg;
    assign bus.rs                 = rs_reg;
    assign bus.rt                 = rt_reg;
    assign bus.rd                 = rd_reg;
    assign bus.shamt              = shamt_reg;
    assign bus.funct              = funct_reg;
    assign bus.read_data_1        = rd1_reg;
    assign bus.read_data_2        = rd2_reg;
    assign bus.extended_immediate = imm_reg;
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed bench for the decode stage: a default instance plus a 64-bit,
// sign-extend-only instance fed the same stimulus.
module tb_decode_stage_pipelined;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    decode_stage_pipelined_if #(.DATA_WIDTH(32)) b32 ();
    decode_stage_pipelined_if #(.DATA_WIDTH(64)) b64 ();

    decode_stage_pipelined #(.DATA_WIDTH(32), .ZERO_EXT_LOGIC(1)) dut (
        .clk(clk), .reset(reset), .bus(b32.slave)
    );
    decode_stage_pipelined #(.DATA_WIDTH(64), .ZERO_EXT_LOGIC(0)) dut64 (
        .clk(clk), .reset(reset), .bus(b64.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive both instances identically
    task automatic drive(input logic iv, input logic [31:0] instr, input logic ordy,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        b32.in_valid = iv;  b64.in_valid = iv;
        b32.instruction = instr; b64.instruction = instr;
        b32.out_ready = ordy; b64.out_ready = ordy;
        b32.wb_en = we;     b64.wb_en = we;
        b32.wb_addr = wa;   b64.wb_addr = wa;
        b32.wb_data = wd;   b64.wb_data = {32'h0, wd};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 32'h0109_5020, 1'b1, 1'b1, 5'd8, 32'h5555_5555);
        tick(); tick();
        $display("[TB] reset");
        chk("reset_out_valid", 64'(b32.out_valid), 64'd0);
        chk("reset_rd1", 64'(b32.read_data_1), 64'd0);
        chk("reset_imm", 64'(b32.extended_immediate), 64'd0);
        chk("reset_in_ready", 64'(b32.in_ready), 64'd1);

        // first decode
        reset = 1'b0;
        drive(1'b1, 32'h0000_0004, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        $display("[TB] decode 00000004");
        chk("nop_valid", 64'(b32.out_valid), 64'd1);
        chk("nop_opcode", 64'(b32.opcode), 64'd0);
        chk("nop_rs", 64'(b32.rs), 64'd0);
        chk("nop_rd", 64'(b32.rd), 64'd0);
        chk("nop_funct", 64'(b32.funct), 64'h04);
        chk("nop_rd1", 64'(b32.read_data_1), 64'd0);
        chk("nop_rd2", 64'(b32.read_data_2), 64'd0);
        chk("nop_imm", 64'(b32.extended_immediate), 64'h4);

        // drain while writing back r8
        drive(1'b0, 32'h0, 1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF);
        tick();
        $display("[TB] drain + wb r8");
        chk("drain_valid", 64'(b32.out_valid), 64'd0);
        chk("drain_funct_kept", 64'(b32.funct), 64'h04);

        // add $10,$8,$9
        drive(1'b1, 32'h0109_5020, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        $display("[TB] decode 01095020");
        chk("add_rd1", 64'(b32.read_data_1), 64'hDEAD_BEEF);
        chk("add_rd2", 64'(b32.read_data_2), 64'd0);
        chk("add_rd", 64'(b32.rd), 64'd10);
        chk("add_rt", 64'(b32.rt), 64'd9);
        chk("add_funct", 64'(b32.funct), 64'h20);
        chk("add_rd1_64", b64.read_data_1, 64'h0000_0000_DEAD_BEEF);

        // same-edge bypass on rt, back to back
        drive(1'b1, 32'h0109_5020, 1'b1, 1'b1, 5'd9, 32'h1234_5678);
        tick();
        $display("[TB] decode 01095020 with wb r9");
        chk("byp_valid", 64'(b32.out_valid), 64'd1);
        chk("byp_rd2", 64'(b32.read_data_2), 64'h1234_5678);
        chk("byp_rd1", 64'(b32.read_data_1), 64'hDEAD_BEEF);

        // ori
        drive(1'b1, 32'h3508_FFFF, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        $display("[TB] decode 3508FFFF");
        chk("ori_opcode", 64'(b32.opcode), 64'h0D);
        chk("ori_imm", 64'(b32.extended_immediate), 64'h0000_FFFF);
        chk("ori_imm_sext64", b64.extended_immediate, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ori_rd2", 64'(b32.read_data_2), 64'hDEAD_BEEF);

        // xori with top immediate bit set
        drive(1'b1, 32'h3908_8000, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        $display("[TB] decode 39088000");
        chk("xori_imm", 64'(b32.extended_immediate), 64'h0000_8000);
        chk("xori_imm_sext64", b64.extended_immediate, 64'hFFFF_FFFF_FFFF_8000);

        // addi
        drive(1'b1, 32'h2108_FFFF, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        $display("[TB] decode 2108FFFF");
        chk("addi_imm", 64'(b32.extended_immediate), 64'hFFFF_FFFF);
        chk("addi_imm64", b64.extended_immediate, 64'hFFFF_FFFF_FFFF_FFFF);

        // hold for three cycles with a new instruction waiting
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("hold_in_ready", 64'(b32.in_ready), 64'd0);
        tick();
        $display("[TB] hold cycle 1");
        chk("hold1_valid", 64'(b32.out_valid), 64'd1);
        chk("hold1_opcode", 64'(b32.opcode), 64'h08);
        chk("hold1_imm", 64'(b32.extended_immediate), 64'hFFFF_FFFF);
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b1, 5'd8, 32'hA5A5_A5A5);
        tick();
        $display("[TB] hold cycle 2 wb r8");
        chk("hold2_rd1", 64'(b32.read_data_1), 64'hA5A5_A5A5);
        chk("hold2_rd2", 64'(b32.read_data_2), 64'hA5A5_A5A5);
        chk("hold2_in_ready", 64'(b32.in_ready), 64'd0);
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b1, 5'd0, 32'h1111_1111);
        tick();
        $display("[TB] hold cycle 3 wb r0");
        chk("hold3_rd1", 64'(b32.read_data_1), 64'hA5A5_A5A5);
        chk("hold3_opcode", 64'(b32.opcode), 64'h08);
        chk("hold3_rs", 64'(b32.rs), 64'd8);

        // reset in the middle of the hold
        reset = 1'b1;
        tick();
        $display("[TB] reset mid-hold");
        chk("rst_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_opcode", 64'(b32.opcode), 64'd0);
        chk("rst_rd1", 64'(b32.read_data_1), 64'd0);
        chk("rst_imm", 64'(b32.extended_immediate), 64'd0);
        reset = 1'b0;
        drive(1'b1, 32'h0109_5020, 1'b1, 1'b1, 5'd0, 32'h1111_1111);
        #1;
        chk("post_rst_in_ready", 64'(b32.in_ready), 64'd1);
        tick();
        $display("[TB] decode 01095020 after reset");
        chk("post_rst_valid", 64'(b32.out_valid), 64'd1);
        chk("post_rst_rd1", 64'(b32.read_data_1), 64'd0);

        // register 0 stays zero after an attempted write
        drive(1'b1, 32'h0000_0020, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        $display("[TB] decode 00000020");
        chk("r0_rd1", 64'(b32.read_data_1), 64'd0);
        chk("r0_funct", 64'(b32.funct), 64'h20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
